// File: rtl/hex_keypad_entry_pkg.sv
// Shared types and constants for the hex keypad entry block: FSM states, key map, column helpers.
package hex_keypad_entry_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_e;

    // Indexed by {row, col}; entry 0 is row 0 / col 0.
    localparam logic [15:0][3:0] KEYMAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    // Walks the single low bit 0->1->2->3->0.
    function automatic logic [3:0] rotate_col(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

    // Index of the lowest low bit; 0 when no bit is low.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/hex_keypad_entry_if.sv
// Keypad pins plus the entry/result signals; master is the keypad entry block, slave its environment.
interface hex_keypad_entry_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        clear_entry;
    logic [15:0] value;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        busy;

    modport master (
        input  row, clear_entry,
        output col, value, key_code, key_valid, busy
    );

    modport slave (
        output row, clear_entry,
        input  col, value, key_code, key_valid, busy
    );
endinterface

// File: rtl/hex_keypad_entry_scan_tick_gen.sv
// Free-running divider; tick strobes for one clk each time the divider wraps.
module hex_keypad_entry_scan_tick_gen #(
    parameter int unsigned SCAN_DIV_BITS = 18
) (
    input  logic clk,
    input  logic clr,
    output logic tick
);

    logic [SCAN_DIV_BITS-1:0] div_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) div_q <= '0;
        else      div_q <= div_q + SCAN_DIV_BITS'(1);
    end

    assign tick = &div_q;

endmodule

// File: rtl/hex_keypad_entry.sv
// 4x4 keypad scanner with press/release debounce, feeding a 16-bit hex entry shift register.
module hex_keypad_entry
    import hex_keypad_entry_pkg::*;
#(
    parameter int unsigned SCAN_DIV_BITS  = 18,
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic               clk,
    input  logic               clr,
    hex_keypad_entry_if.master bus
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_TICKS + 1);

    logic            tick;
    logic [3:0]      row_meta_q, row_sync_q;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      col_q, col_d;
    logic [1:0]      lat_row_q, lat_row_d;
    logic [1:0]      lat_col_q, lat_col_d;
    logic [15:0]     value_q, value_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q;
    logic            accept;
    logic            latched_low;
    logic [3:0]      key_hex;

    hex_keypad_entry_scan_tick_gen #(
        .SCAN_DIV_BITS(SCAN_DIV_BITS)
    ) u_tick (
        .clk (clk),
        .clr (clr),
        .tick(tick)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= bus.row;
            row_sync_q <= row_meta_q;
        end
    end

    assign latched_low = !row_sync_q[lat_row_q];
    assign key_hex     = KEYMAP[{lat_row_q, lat_col_q}];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= SCAN;
            cnt_q       <= '0;
            col_q       <= 4'b1110;
            lat_row_q   <= '0;
            lat_col_q   <= '0;
            value_q     <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            lat_row_q   <= lat_row_d;
            lat_col_q   <= lat_col_d;
            value_q     <= value_d;
            key_code_q  <= key_code_d;
            key_valid_q <= accept;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        col_d     = col_q;
        lat_row_d = lat_row_q;
        lat_col_d = lat_col_q;
        accept    = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (row_sync_q != 4'hF) begin
                        lat_row_d = low_index(row_sync_q);
                        lat_col_d = low_index(col_q);
                        cnt_d     = CntW'(1);
                        state_d   = DEBOUNCE;
                    end else begin
                        col_d = rotate_col(col_q);
                    end
                end
                DEBOUNCE: begin
                    // A bounce returns to SCAN with col unchanged; it moves on the next tick.
                    if (!latched_low) begin
                        cnt_d   = '0;
                        state_d = SCAN;
                    end else if (cnt_q >= CntW'(DEBOUNCE_TICKS)) begin
                        accept  = 1'b1;
                        cnt_d   = '0;
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                HELD: begin
                    // cnt counts consecutive released ticks; any low sample restarts it.
                    if (latched_low) begin
                        cnt_d = '0;
                    end else if (cnt_q >= CntW'(DEBOUNCE_TICKS - 1)) begin
                        cnt_d   = '0;
                        col_d   = rotate_col(col_q);
                        state_d = SCAN;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_comb begin
        key_code_d = accept ? key_hex : key_code_q;
        value_d    = value_q;
        if (bus.clear_entry) value_d = '0;
        else if (accept)     value_d = {value_q[11:0], key_hex};
    end

    assign bus.col       = col_q;
    assign bus.value     = value_q;
    assign bus.key_code  = key_code_q;
    assign bus.key_valid = key_valid_q;
    assign bus.busy      = (state_q != SCAN);

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Directed bench for hex_keypad_entry: behavioural keypad matrix plus a scoreboard of expected keys.
module tb_hex_keypad_entry;

    logic clk;
    logic clr;
    logic [15:0] pressed;
    logic [3:0]  row_m;

    int total;
    int bad;
    int pulses;
    logic [15:0] model_value;
    logic [19:0] sb[$];

    hex_keypad_entry_if bus ();

    hex_keypad_entry #(
        .SCAN_DIV_BITS (2),
        .DEBOUNCE_TICKS(3)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_m = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !bus.col[c]) row_m[r] = 1'b0;
            end
        end
    end
    assign bus.row = row_m;

    always @(posedge clk) begin
        if (bus.key_valid === 1'b1) pulses <= pulses + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n * 4) @(negedge clk);
    endtask

    task automatic expect_key(input logic [3:0] code);
        model_value = {model_value[11:0], code};
        sb.push_back({code, model_value});
    endtask

    task automatic await_pulse(input string tag, input int budget);
        bit seen;
        logic [19:0] e;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.key_valid === 1'b1) seen = 1'b1;
        end
        chk({tag, "_seen"}, 16'(seen), 16'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (seen) begin
                chk({tag, "_code"}, 16'(bus.key_code), 16'(e[19:16]));
                chk({tag, "_value"}, bus.value, e[15:0]);
            end
        end
    endtask

    task automatic wait_busy(input string tag, input logic lvl, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (bus.busy === lvl) ok = 1'b1;
        end
        chk(tag, 16'(ok), 16'd1);
    endtask

    task automatic press_release(input string tag, input int r, input int c,
                                 input logic [3:0] code, input int hold);
        int p0;
        p0 = pulses;
        expect_key(code);
        pressed[r*4+c] = 1'b1;
        await_pulse(tag, 100);
        ticks(hold);
        pressed[r*4+c] = 1'b0;
        wait_busy({tag, "_idle"}, 1'b0, 100);
        chk({tag, "_pulses"}, 16'(pulses - p0), 16'd1);
    endtask

    logic [3:0] exp_col;
    logic [3:0] prev_col;
    int n;
    int p0;
    int kr[5];
    int kc[5];
    logic [3:0] kcode[5];

    initial begin
        total = 0;
        bad = 0;
        pulses = 0;
        model_value = '0;
        pressed = '0;
        bus.clear_entry = 1'b0;
        clr = 1'b0;

        // Reset values, then the idle column walk.
        repeat (3) @(negedge clk);
        chk("rst_col", 16'(bus.col), 16'h000E);
        chk("rst_value", bus.value, 16'h0000);
        chk("rst_valid", 16'(bus.key_valid), 16'd0);
        chk("rst_code", 16'(bus.key_code), 16'd0);
        chk("rst_busy", 16'(bus.busy), 16'd0);
        clr = 1'b1;
        exp_col = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            exp_col = {exp_col[2:0], exp_col[3]};
            prev_col = bus.col;
            n = 0;
            while (bus.col === prev_col && n < 12) begin
                @(negedge clk);
                n++;
            end
            chk("walk_col", 16'(bus.col), 16'(exp_col));
            chk("walk_period", 16'(n), 16'd4);
        end

        // Key '5' held for a long time: exactly one pulse.
        press_release("k5", 1, 1, 4'h5, 10);
        chk("k5_value", bus.value, 16'h0005);

        // Digit entry sequence.
        kr = '{0, 0, 0, 0, 3};
        kc = '{0, 1, 2, 3, 1};
        kcode = '{4'h1, 4'h2, 4'h3, 4'hA, 4'hF};
        for (int k = 0; k < 5; k++) press_release("seq", kr[k], kc[k], kcode[k], 2);
        chk("seq_value", bus.value, 16'h23AF);

        // One-tick bounce on key '1'.
        p0 = pulses;
        pressed[0] = 1'b1;
        wait_busy("bnc_det", 1'b1, 100);
        pressed[0] = 1'b0;
        ticks(6);
        chk("bnc_pulses", 16'(pulses - p0), 16'd0);
        chk("bnc_value", bus.value, model_value);
        chk("bnc_busy", 16'(bus.busy), 16'd0);
        prev_col = bus.col;
        n = 0;
        while (bus.col === prev_col && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("bnc_scan", 16'(bus.col !== prev_col), 16'd1);

        // '1' and '7' together, then a bouncy release.
        p0 = pulses;
        expect_key(4'h1);
        pressed[0] = 1'b1;
        pressed[8] = 1'b1;
        await_pulse("k17", 100);
        ticks(2);
        for (int k = 0; k < 3; k++) begin
            pressed[0] = 1'b0;
            pressed[8] = 1'b0;
            ticks(1);
            pressed[0] = 1'b1;
            pressed[8] = 1'b1;
            ticks(1);
        end
        pressed[0] = 1'b0;
        pressed[8] = 1'b0;
        wait_busy("k17_idle", 1'b0, 100);
        chk("k17_pulses", 16'(pulses - p0), 16'd1);
        press_release("k9", 2, 2, 4'h9, 2);

        // clear_entry on the exact accept edge of 'C' (3 ticks after detection).
        pressed[11] = 1'b1;
        wait_busy("kc_det", 1'b1, 100);
        repeat (11) @(negedge clk);
        bus.clear_entry = 1'b1;
        @(negedge clk);
        bus.clear_entry = 1'b0;
        model_value = '0;
        chk("kc_valid", 16'(bus.key_valid), 16'd1);
        chk("kc_code", 16'(bus.key_code), 16'h000C);
        chk("kc_value", bus.value, 16'h0000);
        pressed[11] = 1'b0;
        wait_busy("kc_idle", 1'b0, 100);
        chk("kc_code_hold", 16'(bus.key_code), 16'h000C);

        // Reset in the middle of debouncing '8'; the held key is re-accepted.
        press_release("k4", 1, 0, 4'h4, 1);
        chk("k4_value", bus.value, 16'h0004);
        pressed[9] = 1'b1;
        wait_busy("k8_det", 1'b1, 100);
        ticks(1);
        clr = 1'b0;
        #1;
        chk("mid_col", 16'(bus.col), 16'h000E);
        chk("mid_value", bus.value, 16'h0000);
        chk("mid_code", 16'(bus.key_code), 16'd0);
        chk("mid_busy", 16'(bus.busy), 16'd0);
        chk("mid_valid", 16'(bus.key_valid), 16'd0);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        model_value = '0;
        expect_key(4'h8);
        await_pulse("k8re", 100);
        pressed[9] = 1'b0;
        wait_busy("k8_idle", 1'b0, 100);
        chk("k8_value", bus.value, 16'h0008);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
